// File: rtl/hex_decoder_if.sv
// Digit-to-segment bus for one HEXn display.
// master drives the digit, slave returns the segments.
interface hex_decoder_if;
  logic [3:0] num;
  logic [6:0] HEX;

  modport master (
    output num,
    input  HEX
  );

  modport slave (
    input  num,
    output HEX
  );
endinterface

// File: rtl/hex_decoder.sv
// 4-bit digit to active-low 7-segment pattern.
// HEX bit0=a ... bit6=g; blank is 7'h7F.
module hex_decoder #(
  parameter bit SHOW_HEX = 1'b1,
  parameter bit REG_OUT  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  hex_decoder_if.slave bus
);

  logic [6:0] hex_d;

  // Segment lookup; letters blank out when SHOW_HEX is off.
  always_comb begin
    hex_d = 7'h7F;
    case (bus.num)
      4'h0: hex_d = 7'h40;
      4'h1: hex_d = 7'h79;
      4'h2: hex_d = 7'h24;
      4'h3: hex_d = 7'h30;
      4'h4: hex_d = 7'h19;
      4'h5: hex_d = 7'h12;
      4'h6: hex_d = 7'h02;
      4'h7: hex_d = 7'h78;
      4'h8: hex_d = 7'h00;
      4'h9: hex_d = 7'h10;
      4'hA: hex_d = SHOW_HEX ? 7'h08 : 7'h7F;
      4'hB: hex_d = SHOW_HEX ? 7'h03 : 7'h7F;
      4'hC: hex_d = SHOW_HEX ? 7'h46 : 7'h7F;
      4'hD: hex_d = SHOW_HEX ? 7'h21 : 7'h7F;
      4'hE: hex_d = SHOW_HEX ? 7'h06 : 7'h7F;
      4'hF: hex_d = SHOW_HEX ? 7'h0E : 7'h7F;
      default: hex_d = 7'h7F;
    endcase
  end

  if (REG_OUT) begin : g_reg
    logic [6:0] hex_q;

    // Output register; reset blanks the digit.
    always_ff @(posedge clk) begin
      if (!reset) hex_q <= 7'h7F;
      else        hex_q <= hex_d;
    end

    assign bus.HEX = hex_q;
  end else begin : g_comb
    logic unused;
    assign unused  = clk ^ reset;
    assign bus.HEX = hex_d;
  end

endmodule

// File: tb/tb_hex_decoder.sv
// Directed bench for hex_decoder.
// Three instances: default, SHOW_HEX=0, REG_OUT=0.
module tb_hex_decoder;
  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  logic [6:0] enc [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_decoder_if b0 ();
  hex_decoder_if b1 ();
  hex_decoder_if b2 ();

  hex_decoder u_def (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  hex_decoder #(.SHOW_HEX(1'b0)) u_nohex (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  hex_decoder #(.REG_OUT(1'b0)) u_comb (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [6:0] got,
    input logic [6:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b0;
    b0.num = 4'd8;
    b1.num = 4'd8;
    b2.num = 4'd8;

    step();
    chk("rst_e1", b0.HEX, 7'h7F);
    chk("rst_e1_nh", b1.HEX, 7'h7F);
    step();
    chk("rst_e2", b0.HEX, 7'h7F);

    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b0.num = 4'(k);
      b1.num = 4'(k);
      b2.num = 4'(k);
      #1;
      chk($sformatf("comb_%0d", k), b2.HEX, enc[k]);
      step();
      chk($sformatf("sweep_%0d", k), b0.HEX, enc[k]);
      chk($sformatf("nohex_%0d", k), b1.HEX,
          (k < 10) ? enc[k] : 7'h7F);
    end

    b1.num = 4'd12;
    step();
    chk("nohex_c", b1.HEX, 7'h7F);
    b1.num = 4'd2;
    step();
    chk("nohex_2", b1.HEX, 7'h24);

    b0.num = 4'd3;
    step();
    chk("lat_3", b0.HEX, 7'h30);
    #2;
    b0.num = 4'd5;
    #1;
    chk("lat_hold", b0.HEX, 7'h30);
    @(negedge clk);
    #4;
    chk("lat_pre", b0.HEX, 7'h30);
    step();
    chk("lat_5", b0.HEX, 7'h12);

    b0.num = 4'd9;
    step();
    chk("mid_9", b0.HEX, 7'h10);
    reset = 1'b0;
    step();
    chk("mid_rst", b0.HEX, 7'h7F);
    reset = 1'b1;
    step();
    chk("mid_rel", b0.HEX, 7'h10);

    reset  = 1'b0;
    #2;
    b2.num = 4'd1;
    #1;
    chk("comb_rst", b2.HEX, 7'h79);
    b2.num = 4'd15;
    #1;
    chk("comb_f", b2.HEX, 7'h0E);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
